// File: rtl/router_fifo.sv
// Per-channel router output FIFO with header marker and packet byte counter.
// Ports: clock, reset, soft_reset, write_enb, read_enb, lfd_state, data_in -> data_out, full, empty.
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       soft_reset,
  input  logic       write_enb,
  input  logic       read_enb,
  input  logic       lfd_state,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef logic [PW-1:0]    ptr_t;
  typedef logic [WIDTH-1:0] word_t;

  ptr_t       wr_ptr_q, wr_ptr_d;
  ptr_t       rd_ptr_q, rd_ptr_d;
  logic [6:0] pkt_cnt_q, pkt_cnt_d;
  logic [7:0] dout_q, dout_d;
  logic       lfd_q;
  word_t      mem_q [DEPTH];

  logic       clr;
  logic       do_wr;
  logic       do_rd;
  word_t      rd_word;
  word_t      wr_word;

  // Extra pointer MSB disambiguates full from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign clr   = reset | soft_reset;
  assign do_wr = write_enb & ~full & ~clr;
  assign do_rd = read_enb & ~empty & ~clr;

  assign rd_word = mem_q[rd_ptr_q[AW-1:0]];
  // lfd_q lines the marker up with the header byte, one cycle late.
  assign wr_word = WIDTH'({lfd_q, data_in});

  assign data_out = dout_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pkt_cnt_d = pkt_cnt_q;
    dout_d    = dout_q;

    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      dout_d   = rd_word[7:0];
      if (rd_word[WIDTH-1]) begin
        // payload length from header plus the parity byte
        pkt_cnt_d = {1'b0, rd_word[7:2]} + 7'd1;
      end else if (pkt_cnt_q != 7'd0) begin
        pkt_cnt_d = pkt_cnt_q - 7'd1;
      end
    end else if (pkt_cnt_q == 7'd0) begin
      // outside a packet the output bus idles at zero
      dout_d = 8'h00;
    end
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pkt_cnt_q <= '0;
      dout_q    <= '0;
      lfd_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
      dout_q    <= dout_d;
      lfd_q     <= lfd_state;
    end
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_word;
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Scoreboard bench for router_fifo.
// Directed vectors; read data checked by an independent monitor.
module tb_router_fifo;

  logic       clock = 1'b0;
  logic       reset;
  logic       soft_reset;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] exp_q [$];

  router_fifo #(.DEPTH(16), .WIDTH(9)) dut (
    .clock     (clock),
    .reset     (reset),
    .soft_reset(soft_reset),
    .write_enb (write_enb),
    .read_enb  (read_enb),
    .lfd_state (lfd_state),
    .data_in   (data_in),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic step(input logic w, input logic r, input logic l,
                      input logic sr, input logic rs,
                      input logic [7:0] din, input logic [7:0] exp);
    write_enb  = w;
    read_enb   = r;
    lfd_state  = l;
    soft_reset = sr;
    reset      = rs;
    data_in    = din;
    if (r) exp_q.push_back(exp);
    @(negedge clock);
  endtask

  task automatic wr(input logic [7:0] b);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, b, 8'h00);
  endtask

  task automatic rd(input logic [7:0] e);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, e);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic lfd();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // Monitor: each accepted read_enb edge yields one data_out sample.
  always begin
    @(posedge clock);
    if (read_enb === 1'b1) begin
      #1;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL mon_underflow: got %0h want none", data_out);
      end else begin
        chk("rd_data", 32'(data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    write_enb = 0; read_enb = 0; lfd_state = 0;
    soft_reset = 0; reset = 1; data_in = 0;

    // reset state
    step(0, 0, 0, 0, 1, 8'h00, 8'h00);
    step(0, 0, 0, 0, 1, 8'h00, 8'h00);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_dout", 32'(data_out), 32'h00);

    // basic packet, header 0x0C -> 3 payload + parity
    lfd();
    wr(8'h0C); wr(8'hA1); wr(8'hA2); wr(8'hA3); wr(8'h5E);
    chk("pkt_nempty", 32'(empty), 32'd0);
    rd(8'h0C); rd(8'hA1);
    idle();
    chk("pkt_hold", 32'(data_out), 32'hA1);
    rd(8'hA2); rd(8'hA3); rd(8'h5E);
    idle();
    chk("pkt_idle0", 32'(data_out), 32'h00);
    chk("pkt_empty", 32'(empty), 32'd1);

    // fill to full, overflow dropped
    for (int i = 0; i < 16; i++) begin
      wr(8'(8'h30 + i));
      if (i == 14) chk("fill_nfull15", 32'(full), 32'd0);
    end
    chk("fill_full", 32'(full), 32'd1);
    wr(8'hFF);
    chk("fill_full17", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) rd(8'(8'h30 + i));
    chk("fill_empty", 32'(empty), 32'd1);
    chk("fill_nfull", 32'(full), 32'd0);
    idle();
    chk("fill_idle0", 32'(data_out), 32'h00);

    // wrap-around
    for (int i = 0; i < 10; i++) wr(8'(8'h50 + i));
    for (int i = 0; i < 10; i++) rd(8'(8'h50 + i));
    chk("wrap_empty1", 32'(empty), 32'd1);
    for (int i = 0; i < 12; i++) begin
      wr(8'(8'hC0 + i));
      chk("wrap_nfull", 32'(full), 32'd0);
    end
    for (int i = 0; i < 12; i++) rd(8'(8'hC0 + i));
    chk("wrap_empty2", 32'(empty), 32'd1);

    // simultaneous read+write when full
    for (int i = 0; i < 16; i++) wr(8'(8'h80 + i));
    chk("sim_full", 32'(full), 32'd1);
    step(1, 1, 0, 0, 0, 8'hEE, 8'h80);
    chk("sim_full_drop", 32'(full), 32'd0);
    for (int i = 1; i < 16; i++) rd(8'(8'h80 + i));
    chk("sim_full_empty", 32'(empty), 32'd1);

    // simultaneous read+write when empty
    step(1, 1, 0, 0, 0, 8'h77, 8'h00);
    chk("sim_emp_nempty", 32'(empty), 32'd0);
    chk("sim_emp_dout", 32'(data_out), 32'h00);
    rd(8'h77);
    chk("sim_emp_empty", 32'(empty), 32'd1);

    // soft reset mid-packet (5 of 8 bytes written)
    lfd();
    wr(8'h18); wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
    rd(8'h18); rd(8'h01);
    chk("sr_pre_dout", 32'(data_out), 32'h01);
    step(1, 1, 0, 1, 0, 8'h99, 8'h00);
    chk("sr_empty", 32'(empty), 32'd1);
    chk("sr_full", 32'(full), 32'd0);
    chk("sr_dout", 32'(data_out), 32'h00);
    idle();
    chk("sr_idle0", 32'(data_out), 32'h00);
    lfd();
    wr(8'h08); wr(8'h11); wr(8'h22); wr(8'h3B);
    rd(8'h08); rd(8'h11); rd(8'h22); rd(8'h3B);
    idle();
    chk("sr_pkt_idle0", 32'(data_out), 32'h00);
    chk("sr_pkt_empty", 32'(empty), 32'd1);

    // hard reset with everything asserted
    wr(8'hD1); wr(8'hD2); wr(8'hD3);
    step(1, 1, 1, 1, 1, 8'h55, 8'h00);
    chk("hr_empty", 32'(empty), 32'd1);
    chk("hr_full", 32'(full), 32'd0);
    chk("hr_dout", 32'(data_out), 32'h00);
    rd(8'h00);
    chk("hr_still_empty", 32'(empty), 32'd1);
    wr(8'h40);
    rd(8'h40);
    idle();
    chk("hr_nomarker", 32'(data_out), 32'h00);

    repeat (2) @(negedge clock);
    chk("q_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of storage words (power of 2).
REQ-002 SHALL have parameter WIDTH, default 9, stored word width: bit 8 header marker, bits 7:0 byte.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high hard reset.
REQ-005 SHALL have port soft_reset  input  1  synchronous, active-high per-channel flush (timeout from FSM).
REQ-006 SHALL have port write_enb  input  1  write request for data_in this cycle.
REQ-007 SHALL have port read_enb  input  1  read request from destination this cycle.
REQ-008 SHALL have port lfd_state  input  1  FSM "load first data" state flag.
REQ-009 SHALL have port data_in  input  8  byte from the router register block dout.
REQ-010 SHALL have port data_out  output  8  registered byte to destination.
REQ-011 SHALL have port full  output  1  combinational, FIFO holds DEPTH words.
REQ-012 SHALL have port empty  output  1  combinational, FIFO holds 0 words.

Function
REQ-013 SHALL use 5-bit write and read pointers (4-bit index + wrap bit); each increments by 1 and wraps 15->0 with wrap-bit toggle.
REQ-014 SHALL drive empty = 1 when pointers are equal in all 5 bits.
REQ-015 SHALL drive full = 1 when index bits are equal and wrap bits differ.
REQ-016 SHALL register lfd_state into lfd_d every cycle; lfd_d aligns the marker with the header byte, which arrives one cycle after lfd_state.
REQ-017 SHALL, when write_enb=1 and full=0, store {lfd_d, data_in} at the write index and increment the write pointer.
REQ-018 SHALL ignore write_enb when full=1: no store, no pointer change.
REQ-019 SHALL, when read_enb=1 and empty=0, load data_out with bits 7:0 of the word at the read index and increment the read pointer; read latency 1 cycle.
REQ-020 SHALL ignore read_enb when empty=1: no pointer change, data_out per REQ-023.
REQ-021 SHALL keep a 7-bit packet counter pkt_cnt: on a read of a word with bit 8=1, load pkt_cnt = word[7:2] + 1 (payload length plus parity byte).
REQ-022 SHALL decrement pkt_cnt by 1 on a read of a word with bit 8=0 while pkt_cnt != 0; never underflow below 0.
REQ-023 SHALL drive data_out to 0 on any cycle without a successful read while pkt_cnt = 0; otherwise hold its value.
REQ-024 SHALL evaluate full/empty from pre-edge pointers for simultaneous read and write: when full, read done and write dropped; when empty, write done and read ignored; otherwise both done, occupancy unchanged.
REQ-025 SHALL, on soft_reset=1 (reset=0), clear both pointers, pkt_cnt, lfd_d, data_out and all storage words to 0, ignoring same-cycle read/write.

Reset
REQ-026 SHALL, on reset=1, clear pointers, pkt_cnt, lfd_d, data_out and all storage to 0; reset takes priority over soft_reset, read_enb and write_enb.
REQ-027 SHALL present after reset or soft_reset: empty=1, full=0, data_out=0x00.
REQ-028 SHALL, on reset or soft_reset asserted mid-packet, discard the partial packet; the next accepted write is treated as a fresh stream.

Verification
REQ-029 SHALL cover basic packet: lfd_state=1 in cycle N, writes 0x0C(hdr, N+1), 0xA1, 0xA2, 0xA3, parity 0x5E -> reads return 0x0C,0xA1,0xA2,0xA3,0x5E one cycle after each read_enb; pkt_cnt goes 4,3,2,1,0; data_out=0x00 on next idle cycle.
REQ-030 SHALL cover fill to full: 16 writes with no reads -> full=1 after 16th; 17th write dropped; 16 reads return the original 16 bytes in order, then empty=1.
REQ-031 SHALL cover wrap-around: write 10, read 10, write 12 -> pointers wrap past 15; reads return the 12 bytes in order; full never asserts.
REQ-032 SHALL cover simultaneous read+write when full -> read returns oldest byte, write dropped, full deasserts next cycle; when empty -> write stored, data_out unchanged/0, empty deasserts.
REQ-033 SHALL cover soft_reset after 5 of 8 packet bytes written -> empty=1, full=0, data_out=0x00 next cycle; following 0x08 header packet reads back intact.
REQ-034 SHALL cover reset asserted with soft_reset, read_enb, write_enb all high -> all state cleared, no byte stored.
